uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised next-generation UART receiver: configurable data width, optional second stop bit, 3-sample majority voting, break detection and a status-tagged receive FIFO with read handshake. It sits between the RX pin and the host register interface, replacing the single-frame receiver. Every received frame, good or bad, is queued with its error flags so that software can drain frames in bursts.

## Interface
- DATA_WIDTH, 8, data bits per frame, 5..9
- FIFO_DEPTH, 4, receive FIFO entries, power of 2, >= 2
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RX_IN  in  1  serial line, asynchronous, idle high
- prescale  in  6  oversampling ratio, 8..32, even
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  1 = two stop bits
- RD_EN  in  1  pop FIFO head
- CLR_OVR  in  1  clear OVERRUN
- P_DATA  out  DATA_WIDTH  head entry data
- PAR_ERR  out  1  head entry parity error
- STP_ERR  out  1  head entry framing error
- BRK_DET  out  1  head entry is a break
- data_valid  out  1  FIFO not empty
- OVERRUN  out  1  sticky: frame dropped because FIFO was full

## Operation
- RX_IN passes through a 2-flop synchroniser that resets to 1. All decisions use the synchronised value `rxs`.
- Configuration latch: prescale, PAR_EN, PAR_TYP and STOP2 are latched on the IDLE->START transition. Changing them mid-frame has no effect on that frame.
- Edge counter: runs 0..P-1 per bit, where P is the latched prescale.
- Majority vote: samples are taken at edges P/2-1, P/2 and P/2+1. The bit value is the majority of the three and is registered at edge P/2+1.
- State transitions occur at edge P-1 unless stated otherwise.
- States:
  - IDLE: when `rxs`=0, go to START with edge counter = 0.
  - START: if the voted bit is 1 (glitch), go to IDLE; nothing is queued and no flag is set. Otherwise go to DATA.
  - DATA: receives DATA_WIDTH bits, LSB first. After the last bit go to PARITY if PAR_EN, else STOP.
  - PARITY: error if XOR(data, parity bit) != PAR_TYP.
  - STOP: a voted 0 sets the framing error. If STOP2, go to STOP_2; otherwise complete the frame.
  - STOP_2: same check as STOP, then complete the frame.
  - BRK_WAIT: entered after completing a break frame. Stays until `rxs`=1, then goes to IDLE.
- Frame completion: push {BRK, FRM, PAR, data} and go to IDLE (or BRK_WAIT for a break).
- Break: data is all 0, the parity bit (if present) is 0 and the first stop bit is 0. A break entry has STP_ERR=1, BRK_DET=1 and PAR_ERR as computed.
- FIFO is show-ahead: outputs always reflect the head entry. RD_EN with data_valid=1 pops; RD_EN while empty is ignored.
- Push while full: the frame is dropped, OVERRUN is set and the FIFO contents are unchanged. Exception: a simultaneous pop frees a slot, so both succeed and OVERRUN is not set.
- OVERRUN clears on CLR_OVR=1. If CLR_OVR and a drop occur in the same cycle, set wins.
- When empty, P_DATA and the flags hold the last popped values (0 after reset).

## Timing
- Reset values (cycle after RST=1): P_DATA=0, PAR_ERR=0, STP_ERR=0, BRK_DET=0, data_valid=0, OVERRUN=0. FIFO is emptied, FSM is in IDLE, synchroniser holds 1s, edge counter is 0.
- RST asserted mid-frame aborts the frame with no push. Reception resumes on the next falling edge after release.
- Start detect: 2 cycles after RX_IN falls (synchroniser), START is entered.
- Frame length in cycles: P*(1+DATA_WIDTH+PAR_EN+1+STOP2).
- Push happens at edge P-1 of the final stop bit. data_valid and the head outputs update 1 cycle later.
- Pop: the head advances on the RD_EN edge, and the new head (or data_valid=0) is visible the next cycle.
- Back-to-back frames: a start bit that follows the stop bit with no idle gap is detected, because IDLE is re-entered at the end of the stop bit.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits wide. Read and write pointers wrap modulo FIFO_DEPTH.

## Test plan
- DATA_WIDTH=8, prescale=8, no parity, 1 stop, send 0xA5 -> one entry: P_DATA=0xA5, all flags 0, data_valid rises 1 cycle after the 10th bit's edge 7; RD_EN -> data_valid=0.
- PAR_EN=1, PAR_TYP=0, send 0x03 with parity bit 1 -> PAR_ERR=1, STP_ERR=0. Repeat with parity bit 0 -> PAR_ERR=0.
- RX_IN low for 3 cycles only (prescale=16); separately, a single-cycle glitch inside a data bit -> no entry for the short start; for the data glitch, the bit is unchanged by the majority vote and the frame decodes correctly.
- STOP2=1, second stop bit driven 0 -> STP_ERR=1, BRK_DET=0. Then hold RX_IN low for 3 frame-times -> one break entry (P_DATA=0, STP_ERR=1, BRK_DET=1) and no further entries until the line returns high.
- FIFO_DEPTH=4, send 0x11..0x55 with no reads -> entries 0x11..0x44 are kept and OVERRUN=1. Repeat with RD_EN pulsed on the 5th frame's push cycle -> OVERRUN stays 0. CLR_OVR -> OVERRUN=0.
- RST pulsed during DATA bit 4 -> no entry and all outputs 0. The next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a status-tagged show-ahead receive FIFO.
//
// Every frame (good, bad or break) is pushed as {BRK, FRM, PAR, data}.
// Ports:
//   CLK, RST          system clock, synchronous active-high reset
//   RX_IN             asynchronous serial line, idle high
//   prescale          oversampling ratio (8..32, even), latched at start of frame
//   PAR_EN, PAR_TYP   parity present / odd parity, latched at start of frame
//   STOP2             two stop bits, latched at start of frame
//   RD_EN             pop the FIFO head (ignored while empty)
//   CLR_OVR           clear the sticky OVERRUN flag
//   P_DATA            head entry data (last popped value while empty)
//   PAR_ERR, STP_ERR  head entry parity / framing error
//   BRK_DET           head entry is a break
//   data_valid        FIFO not empty
//   OVERRUN           sticky: a completed frame was dropped on a full FIFO
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  RD_EN,
    input  logic                  CLR_OVR,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BRK_DET,
    output logic                  data_valid,
    output logic                  OVERRUN
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = DATA_WIDTH + 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StStop2,
        StBrkWait
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic sync_q;
    logic rxs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_q <= RX_IN;
            rxs    <= sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t                state;
    logic [5:0]            cfg_p;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic                  cfg_stop2;
    logic [5:0]            cnt;
    logic [3:0]            bit_idx;
    logic                  s0;
    logic                  s1;
    logic                  bit_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pbit_q;
    logic                  par_err_q;
    logic                  frm_err_q;
    logic                  brk_q;

    logic [5:0] half;
    logic [5:0] last;
    logic       bit_end;
    logic       brk_now;

    assign half    = {1'b0, cfg_p[5:1]};
    assign last    = cfg_p - 6'd1;
    assign bit_end = (cnt == last);
    // Break signature as seen while the first stop bit is being closed out.
    assign brk_now = (data_q == '0) && !pbit_q && !bit_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= StIdle;
            cfg_p       <= 6'd8;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            cfg_stop2   <= 1'b0;
            cnt         <= '0;
            bit_idx     <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            bit_q       <= 1'b1;
            data_q      <= '0;
            pbit_q      <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            // Bit timing and 3-sample majority vote around the bit centre.
            if (state != StIdle && state != StBrkWait) begin
                if (cnt == half - 6'd1) s0 <= rxs;
                if (cnt == half)        s1 <= rxs;
                if (cnt == half + 6'd1) bit_q <= (s0 & s1) | (s0 & rxs) | (s1 & rxs);
                cnt <= bit_end ? 6'd0 : cnt + 6'd1;
            end

            case (state)
                StIdle: begin
                    if (!rxs) begin
                        state       <= StStart;
                        cnt         <= '0;
                        cfg_p       <= prescale;
                        cfg_par_en  <= PAR_EN;
                        cfg_par_typ <= PAR_TYP;
                        cfg_stop2   <= STOP2;
                        bit_idx     <= '0;
                        pbit_q      <= 1'b0;
                        par_err_q   <= 1'b0;
                        frm_err_q   <= 1'b0;
                        brk_q       <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) state <= bit_q ? StIdle : StData;
                end
                StData: begin
                    if (bit_end) begin
                        data_q  <= {bit_q, data_q[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'(DATA_WIDTH - 1)) begin
                            state <= cfg_par_en ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        pbit_q    <= bit_q;
                        par_err_q <= ((^data_q) ^ bit_q) != cfg_par_typ;
                        state     <= StStop;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        frm_err_q <= ~bit_q;
                        brk_q     <= brk_now;
                        if (cfg_stop2) state <= StStop2;
                        else           state <= brk_now ? StBrkWait : StIdle;
                    end
                end
                StStop2: begin
                    if (bit_end) state <= brk_q ? StBrkWait : StIdle;
                end
                StBrkWait: begin
                    if (rxs) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Frame completion strobe, on the closing edge of the final stop bit.
    logic          push;
    logic [EW-1:0] push_entry;

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (bit_end && state == StStop && !cfg_stop2) begin
            push       = 1'b1;
            push_entry = {brk_now, ~bit_q, par_err_q, data_q};
        end else if (bit_end && state == StStop2) begin
            push       = 1'b1;
            push_entry = {brk_q, frm_err_q | ~bit_q, par_err_q, data_q};
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead receive FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] last_q;
    logic          ovr_q;

    logic full;
    logic empty;
    logic pop;
    logic do_push;
    logic drop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = RD_EN && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (!RST && do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)         ovr_q <= 1'b1;
            else if (CLR_OVR) ovr_q <= 1'b0;
        end
    end

    logic [EW-1:0] head;
    assign head = empty ? last_q : mem[rd_ptr];

    assign P_DATA     = head[DATA_WIDTH-1:0];
    assign PAR_ERR    = head[DATA_WIDTH];
    assign STP_ERR    = head[DATA_WIDTH+1];
    assign BRK_DET    = head[DATA_WIDTH+2];
    assign data_valid = !empty;
    assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, a queue-based reference model of the
// receive FIFO fed with frame results computed from the transmitted bit levels,
// and a per-cycle compare of all DUT outputs against that model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [5:0]    prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic          RD_EN;
    logic          CLR_OVR;
    logic [DW-1:0] P_DATA;
    logic          PAR_ERR;
    logic          STP_ERR;
    logic          BRK_DET;
    logic          data_valid;
    logic          OVERRUN;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .prescale   (prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .RD_EN      (RD_EN),
        .CLR_OVR    (CLR_OVR),
        .P_DATA     (P_DATA),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .BRK_DET    (BRK_DET),
        .data_valid (data_valid),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          at;
        logic [10:0] e;
    } pend_t;

    int          total = 0;
    int          bad = 0;
    int          edge_no = 0;
    int          idle_from = 0;
    int          last_push_at = 0;
    pend_t       pend[$];
    logic [10:0] mq[$];
    logic [10:0] mlast;
    logic        movr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h, want %0h", nm, edge_no, act, exp);
        end
    endtask

    // Frame result straight from the line levels: {BRK, FRM, PAR, data}.
    function automatic logic [10:0] model_entry(input logic [7:0] d, input logic pe,
                                                input logic pt, input logic s2en,
                                                input logic pbit, input logic s1,
                                                input logic s2);
        logic brk, frm, par;
        brk = (d == 8'h00) && (!pe || !pbit) && !s1;
        frm = !s1 || (s2en && !s2);
        par = pe && (((^d) ^ pbit) != pt);
        return {brk, frm, par, d};
    endfunction

    // Reference model and per-cycle compare.
    logic [10:0] m_head;
    logic [10:0] m_e;
    logic        m_push;
    logic        m_pop;
    logic        m_full;
    pend_t       m_pd;

    initial begin : model_chk
        mlast = '0;
        movr  = 1'b0;
        forever begin
            @(posedge CLK);
            edge_no++;
            if (RST) begin
                mq.delete();
                pend.delete();
                mlast = '0;
                movr  = 1'b0;
            end else begin
                while (pend.size() > 0 && pend[0].at < edge_no) m_pd = pend.pop_front();
                m_push = 1'b0;
                m_e    = '0;
                if (pend.size() > 0 && pend[0].at == edge_no) begin
                    m_pd   = pend.pop_front();
                    m_e    = m_pd.e;
                    m_push = 1'b1;
                end
                m_full = (mq.size() == DEPTH);
                m_pop  = RD_EN && (mq.size() > 0);
                if (m_pop) mlast = mq.pop_front();
                if (m_push) begin
                    if (!m_full || m_pop) mq.push_back(m_e);
                    else                  movr = 1'b1;
                end
                if (!(m_push && m_full && !m_pop) && CLR_OVR) movr = 1'b0;
            end
            @(negedge CLK);
            m_head = (mq.size() > 0) ? mq[0] : mlast;
            chk("m_valid", 32'(data_valid), 32'(mq.size() > 0));
            chk("m_data", 32'(P_DATA), 32'(m_head[7:0]));
            chk("m_par", 32'(PAR_ERR), 32'(m_head[8]));
            chk("m_stp", 32'(STP_ERR), 32'(m_head[9]));
            chk("m_brk", 32'(BRK_DET), 32'(m_head[10]));
            chk("m_ovr", 32'(OVERRUN), 32'(movr));
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                              input logic s2, input int glitch, input int gap);
        logic [11:0] fb;
        int          p, nb, k, t, start;
        p  = int'(prescale);
        nb = 1 + DW + int'(PAR_EN) + 1 + int'(STOP2);
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = d;
        k = 9;
        if (PAR_EN) begin
            fb[k] = pbit;
            k++;
        end
        fb[k] = s1;
        k++;
        if (STOP2) fb[k] = s2;
        t     = edge_no + 1;
        start = (t + 2 > idle_from) ? t + 2 : idle_from;
        last_push_at = start + nb * p;
        idle_from    = last_push_at + 1;
        pend.push_back('{at: last_push_at,
                         e: model_entry(d, PAR_EN, PAR_TYP, STOP2, pbit, s1, s2)});
        for (int i = 0; i < nb * p; i++) begin
            RX_IN = fb[i / p] ^ (i == glitch);
            @(negedge CLK);
        end
        RX_IN = 1'b1;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic wait_edge(input int e);
        while (edge_no < e) @(negedge CLK);
    endtask

    task automatic pop();
        RD_EN = 1'b1;
        @(negedge CLK);
        RD_EN = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        chk("pop_valid", 32'(data_valid), 32'd1);
        chk("pop_head", 32'(P_DATA), 32'(exp));
        pop();
    endtask

    initial begin : stim
        int nb, t;
        RX_IN = 1'b1; RST = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        STOP2 = 1'b0; RD_EN = 1'b0; CLR_OVR = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(P_DATA), 32'd0);
        chk("rst_flags", {29'd0, PAR_ERR, STP_ERR, BRK_DET}, 32'd0);
        chk("rst_ovr", 32'(OVERRUN), 32'd0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Plain 8N1 frame and its push latency.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, 0);
        wait_edge(last_push_at - 1);
        chk("a5_valid_early", 32'(data_valid), 32'd0);
        @(negedge CLK);
        chk("a5_valid", 32'(data_valid), 32'd1);
        chk("a5_data", 32'(P_DATA), 32'hA5);
        chk("a5_flags", {29'd0, PAR_ERR, STP_ERR, BRK_DET}, 32'd0);
        pop();
        chk("a5_empty", 32'(data_valid), 32'd0);
        chk("a5_hold", 32'(P_DATA), 32'hA5);
        repeat (8) @(negedge CLK);

        // Even parity: 0x03 has even ones, so parity bit 1 is wrong.
        PAR_EN = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1, 16);
        chk("par1_err", 32'(PAR_ERR), 32'd1);
        chk("par1_stp", 32'(STP_ERR), 32'd0);
        pop();
        send_frame(8'h03, 1'b0, 1'b1, 1'b1, -1, 16);
        chk("par0_err", 32'(PAR_ERR), 32'd0);
        pop();
        PAR_EN = 1'b0;

        // Short start pulse, then a one-cycle glitch on the centre sample of data bit 1.
        prescale = 6'd16;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (48) @(negedge CLK);
        chk("short_start", 32'(data_valid), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 2 * 16 + 9, 24);
        chk("glitch_data", 32'(P_DATA), 32'h5A);
        chk("glitch_stp", 32'(STP_ERR), 32'd0);
        pop();
        prescale = 6'd8;

        // Bad second stop bit, then a long break.
        STOP2 = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1, 16);
        chk("stop2_stp", 32'(STP_ERR), 32'd1);
        chk("stop2_brk", 32'(BRK_DET), 32'd0);
        pop();
        nb = 11;
        t  = edge_no + 1;
        pend.push_back('{at: t + 2 + nb * 8,
                         e: model_entry(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)});
        RX_IN = 1'b0;
        repeat (3 * nb * 8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (32) @(negedge CLK);
        idle_from = 0;
        chk("brk_valid", 32'(data_valid), 32'd1);
        chk("brk_data", 32'(P_DATA), 32'd0);
        chk("brk_flags", {30'd0, STP_ERR, BRK_DET}, 32'd3);
        pop();
        chk("brk_single", 32'(data_valid), 32'd0);
        STOP2 = 1'b0;

        // Overflow: fifth frame dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'(8'h11 * i), 1'b0, 1'b1, 1'b1, -1, 16);
        chk("ovr_set", 32'(OVERRUN), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(8'h11 * i));
        chk("ovr_drained", 32'(data_valid), 32'd0);
        CLR_OVR = 1'b1;
        @(negedge CLK);
        CLR_OVR = 1'b0;
        chk("ovr_clr", 32'(OVERRUN), 32'd0);

        // Pop on the fifth push edge makes room.
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h11 * i), 1'b0, 1'b1, 1'b1, -1, 16);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, -1, 0);
        wait_edge(last_push_at - 1);
        pop();
        chk("ovr_avoided", 32'(OVERRUN), 32'd0);
        for (int i = 2; i <= 5; i++) pop_expect(8'(8'h11 * i));
        chk("fifo_empty", 32'(data_valid), 32'd0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, 1'b0, 1'b1, 1'b1, -1, 0);
        send_frame(8'h34, 1'b0, 1'b1, 1'b1, -1, 16);
        pop_expect(8'h12);
        pop_expect(8'h34);

        // Reset in the middle of data bit 4, with an older entry still queued.
        send_frame(8'h77, 1'b0, 1'b1, 1'b1, -1, 8);
        RX_IN = 1'b0;
        repeat (5 * 8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        idle_from = 0;
        repeat (24) @(negedge CLK);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(P_DATA), 32'd0);
        chk("mid_rst_flags", {28'd0, PAR_ERR, STP_ERR, BRK_DET, OVERRUN}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, 16);
        pop_expect(8'h3C);

        repeat (8) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
